pu_riscv_ahb3_htif: RTL and testbench

PU_RISCV_AHB3_HTIF -- requirements
Module: pu_riscv_ahb3_htif

---
 rtl/peripheral_ahb3_verilog_pkg.sv | 36 +++
 rtl/pu_riscv_htif_fifo.sv | 53 +++++
 rtl/pu_riscv_ahb3_htif.sv | 174 +++++++++++++++++
 tb/tb_pu_riscv_ahb3_htif.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_ahb3_verilog_pkg.sv
// Shared AHB3 encodings and the HTIF slave state type.
// Imported by the HTIF top; address defaults stay module parameters.
package peripheral_ahb3_verilog_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Largest transfer size the slave accepts (32-bit word).
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } htif_state_t;

    // True for transfer types that start a real bus access.
    function automatic logic is_xfer(input logic [1:0] htrans);
        logic r;
        r = 1'b0;
        unique case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: r = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  r = 1'b0;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pu_riscv_htif_fifo.sv
// Byte FIFO for the HTIF UART TX path; head byte is combinational.
// Ports: clk, rst (sync high), push/wdata, pop/rdata, full, empty, count.
module pu_riscv_htif_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // A pop frees the slot the same cycle, so a full FIFO can
    // still take a push when it is popped simultaneously.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pu_riscv_ahb3_htif.sv
// AHB3 slave exposing a TOHOST exit register and a UART TX byte FIFO.
// Ports: AHB3 slave (HCLK/HRESET ...), tx_data/valid/ready, tohost/_stb.
module pu_riscv_ahb3_htif #(
    parameter int              XLEN       = 32,
    parameter int              PLEN       = 32,
    parameter logic [PLEN-1:0] TOHOST     = 'h80001000,
    parameter logic [PLEN-1:0] UART_TX    = 'h80001080,
    parameter int              FIFO_DEPTH = 8
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            HSEL,
    input  logic [PLEN-1:0] HADDR,
    input  logic [XLEN-1:0] HWDATA,
    output logic [XLEN-1:0] HRDATA,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [2:0]      HBURST,
    input  logic [3:0]      HPROT,
    input  logic [1:0]      HTRANS,
    input  logic            HMASTLOCK,
    input  logic            HREADY,
    output logic            HREADYOUT,
    output logic            HRESP,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [XLEN-1:0] tohost,
    output logic            tohost_stb
);

    import peripheral_ahb3_verilog_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PLEN-1:0] UART_ST = UART_TX + PLEN'(4);

    htif_state_t     state_q;
    htif_state_t     state_d;
    logic [PLEN-1:0] addr_q;
    logic            write_q;
    logic [2:0]      size_q;

    logic            capture;
    logic            legal;
    logic            sel_th;
    logic            sel_tx;
    logic            sel_st;

    logic            rdy;
    logic            resp;
    logic [XLEN-1:0] rdata;
    logic            push;
    logic            pop;
    logic            can_push;
    logic            tohost_we;

    logic            full;
    logic            empty;
    logic [AW:0]     count;
    logic [XLEN-1:0] status;

    logic            unused;
    assign unused = ^{HBURST, HPROT, HMASTLOCK,
                      HADDR[1:0], addr_q[1:0], size_q};

    assign capture = HSEL & HREADY & is_xfer(HTRANS);

    // Decode on the live address phase to pick DATA vs ERR1.
    assign legal = ((HADDR[PLEN-1:2] == TOHOST[PLEN-1:2])
                 |  (HADDR[PLEN-1:2] == UART_TX[PLEN-1:2])
                 |  (HADDR[PLEN-1:2] == UART_ST[PLEN-1:2]))
                 & (HSIZE <= HSIZE_WORD);

    assign sel_th = (addr_q[PLEN-1:2] == TOHOST[PLEN-1:2]);
    assign sel_tx = (addr_q[PLEN-1:2] == UART_TX[PLEN-1:2]);
    assign sel_st = (addr_q[PLEN-1:2] == UART_ST[PLEN-1:2]);

    assign tx_valid = ~empty;
    assign pop      = tx_valid & tx_ready;
    assign can_push = ~full | pop;

    always_comb begin
        status         = '0;
        status[AW+2:2] = count;
        status[1]      = full;
        status[0]      = empty;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                size_q  <= HSIZE;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rdy       = 1'b1;
        resp      = HRESP_OKAY;
        rdata     = '0;
        push      = 1'b0;
        tohost_we = 1'b0;
        unique case (state_q)
            ST_IDLE: ;
            ST_DATA: begin
                if (write_q && sel_tx && !can_push) begin
                    rdy     = 1'b0;
                    state_d = ST_WAIT;
                end else if (write_q) begin
                    push      = sel_tx;
                    tohost_we = sel_th;
                end else if (sel_th) begin
                    rdata = tohost;
                end else if (sel_st) begin
                    rdata = status;
                end
            end
            ST_WAIT: begin
                if (can_push) push = 1'b1;
                else          rdy  = 1'b0;
            end
            ST_ERR1: begin
                rdy     = 1'b0;
                resp    = HRESP_ERROR;
                state_d = ST_ERR2;
            end
            ST_ERR2: resp = HRESP_ERROR;
            default: state_d = ST_IDLE;
        endcase
        // Completing cycle: pipeline straight into the next transfer.
        if (rdy) begin
            if (capture) state_d = legal ? ST_DATA : ST_ERR1;
            else         state_d = ST_IDLE;
        end
    end

    assign HREADYOUT = rdy;
    assign HRESP     = resp;
    assign HRDATA    = rdata;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            tohost     <= '0;
            tohost_stb <= 1'b0;
        end else begin
            tohost_stb <= tohost_we;
            if (tohost_we) tohost <= HWDATA;
        end
    end

    pu_riscv_htif_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (push),
        .wdata (HWDATA[7:0]),
        .pop   (pop),
        .rdata (tx_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_pu_riscv_ahb3_htif.sv
// Self-checking bench for pu_riscv_ahb3_htif.
// Directed bus scenarios plus randomized traffic vs a queue model.
module tb_pu_riscv_ahb3_htif;

    localparam logic [31:0] TOHOST = 32'h80001000;
    localparam logic [31:0] UART   = 32'h80001080;
    localparam logic [31:0] USTAT  = 32'h80001084;

    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tohost;
    logic        tohost_stb;

    int          total;
    int          bad;
    bit          mon_en;
    bit          rand_en;
    logic [7:0]  model_q [$];
    logic [7:0]  popped [$];
    logic [31:0] tohost_m;

    assign HREADY = HREADYOUT;

    pu_riscv_ahb3_htif dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HWDATA     (HWDATA),
        .HRDATA     (HRDATA),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HPROT      (HPROT),
        .HTRANS     (HTRANS),
        .HMASTLOCK  (HMASTLOCK),
        .HREADY     (HREADY),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tohost     (tohost),
        .tohost_stb (tohost_stb)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] status_of(input int n);
        return (32'(n) << 2) | ((n == 8) ? 32'h2 : 32'h0)
             | ((n == 0) ? 32'h1 : 32'h0);
    endfunction

    // Consumer side: every popped byte must be the oldest pushed one.
    always @(negedge HCLK) begin
        if (mon_en) begin
            check("tx_valid", tx_valid, model_q.size() != 0);
            if (tx_valid && tx_ready && model_q.size() != 0) begin
                check("tx_data", tx_data, model_q[0]);
                popped.push_back(tx_data);
                void'(model_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge HCLK);
            #2;
            if (rand_en) tx_ready = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic xfer(input logic [31:0] a, input bit wr,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output int waits,
                        output bit err, output bit saw1, output int snap);
        bit done;
        done  = 0;
        rd    = '0;
        waits = 0;
        err   = 0;
        saw1  = 0;
        HSEL   = 1'b1;
        HADDR  = a;
        HWRITE = wr;
        HSIZE  = sz;
        HTRANS = 2'b10;
        @(posedge HCLK);
        #1;
        snap   = model_q.size();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = wd;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge HCLK);
            if (HREADYOUT) begin
                rd   = HRDATA;
                err  = HRESP;
                done = 1;
            end else begin
                waits++;
                if (HRESP) saw1 = 1;
            end
            @(posedge HCLK);
            #1;
        end
        check("xfer_done", done, 1);
    endtask

    task automatic post_tohost(input logic [31:0] v);
        @(negedge HCLK);
        check("stb_hi", tohost_stb, 1);
        check("tohost", tohost, v);
        @(negedge HCLK);
        check("stb_lo", tohost_stb, 0);
    endtask

    task automatic drain();
        rand_en  = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 40 && model_q.size() != 0; i++)
            @(posedge HCLK);
        @(negedge HCLK);
        check("drain", tx_valid, 0);
        #1 tx_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          w;
        int          snap;
        bit          err;
        bit          s1;

        total = 0; bad = 0; mon_en = 0; rand_en = 0;
        tohost_m = '0;
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWDATA = '0;
        HWRITE = 1'b0; HSIZE = 3'd2; HBURST = '0; HPROT = '0;
        HTRANS = 2'b00; HMASTLOCK = 1'b0; tx_ready = 1'b0;

        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_ready", HREADYOUT, 1);
        check("rst_resp", HRESP, 0);
        check("rst_rdata", HRDATA, 0);
        check("rst_tohost", tohost, 0);
        check("rst_stb", tohost_stb, 0);
        check("rst_txv", tx_valid, 0);
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        mon_en = 1;

        // TOHOST write then read back.
        xfer(TOHOST, 1, 3'd2, 32'h1, rd, w, err, s1, snap);
        check("th_w_resp", err, 0);
        check("th_w_wait", w, 0);
        tohost_m = 32'h1;
        post_tohost(32'h1);
        xfer(TOHOST, 0, 3'd2, 32'h0, rd, w, err, s1, snap);
        check("th_r_data", rd, 32'h1);
        check("th_r_resp", err, 0);
        check("th_r_wait", w, 0);

        // Fill the FIFO with the consumer stalled.
        for (int k = 0; k < 8; k++) begin
            xfer(UART, 1, 3'd0, 32'h41 + 32'(k), rd, w, err, s1, snap);
            model_q.push_back(8'h41 + 8'(k));
            check("fill_wait", w, 0);
            check("fill_resp", err, 0);
        end
        xfer(USTAT, 0, 3'd2, 32'h0, rd, w, err, s1, snap);
        check("full_stat", rd, 32'h22);

        // Ninth write stalls until a single pop frees a slot.
        fork
            xfer(UART, 1, 3'd0, 32'h49, rd, w, err, s1, snap);
            begin
                repeat (3) @(posedge HCLK);
                #1 tx_ready = 1'b1;
                @(posedge HCLK);
                #1 tx_ready = 1'b0;
            end
        join
        model_q.push_back(8'h49);
        check("stall_wait", w, 2);
        check("stall_resp", err, 0);
        check("stall_pop", popped.size(), 1);
        xfer(USTAT, 0, 3'd2, 32'h0, rd, w, err, s1, snap);
        check("stall_stat", rd, 32'h22);

        // Unmapped write: two-cycle error, no side effects.
        xfer(32'h80001008, 1, 3'd2, 32'hdead, rd, w, err, s1, snap);
        check("bad_first", s1, 1);
        check("bad_wait", w, 1);
        check("bad_resp", err, 1);
        check("bad_tohost", tohost, tohost_m);
        xfer(USTAT, 0, 3'd2, 32'h0, rd, w, err, s1, snap);
        check("bad_stat", rd, 32'h22);

        // Oversized read of a mapped register.
        xfer(TOHOST, 0, 3'd3, 32'h0, rd, w, err, s1, snap);
        check("sz_first", s1, 1);
        check("sz_wait", w, 1);
        check("sz_resp", err, 1);

        // Back-to-back pipelined byte writes.
        drain();
        popped.delete();
        tx_ready = 1'b1;
        HSEL = 1'b1; HADDR = UART; HWRITE = 1'b1;
        HSIZE = 3'd0; HTRANS = 2'b10;
        @(posedge HCLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            HWDATA = 32'h61 + 32'(k);
            if (k == 2) begin
                HSEL   = 1'b0;
                HTRANS = 2'b00;
            end
            @(negedge HCLK);
            check("b2b_ready", HREADYOUT, 1);
            check("b2b_resp", HRESP, 0);
            @(posedge HCLK);
            model_q.push_back(8'h61 + 8'(k));
            #1;
        end
        repeat (4) @(posedge HCLK);
        #1 tx_ready = 1'b0;
        check("b2b_cnt", popped.size(), 3);
        for (int k = 0; k < 3 && k < popped.size(); k++)
            check("b2b_seq", popped[k], 8'h61 + 8'(k));

        // Reset in the middle of a full-FIFO stall.
        for (int k = 0; k < 8; k++) begin
            xfer(UART, 1, 3'd0, 32'h30 + 32'(k), rd, w, err, s1, snap);
            model_q.push_back(8'h30 + 8'(k));
        end
        HSEL = 1'b1; HADDR = UART; HWRITE = 1'b1;
        HSIZE = 3'd0; HTRANS = 2'b10;
        @(posedge HCLK);
        #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h5a;
        @(negedge HCLK);
        check("wr_stall", HREADYOUT, 0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        mon_en = 0;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        model_q.delete();
        tohost_m = '0;
        @(negedge HCLK);
        check("rr_ready", HREADYOUT, 1);
        check("rr_txv", tx_valid, 0);
        mon_en = 1;
        xfer(USTAT, 0, 3'd2, 32'h0, rd, w, err, s1, snap);
        check("rr_stat", rd, 32'h1);
        check("rr_tohost", tohost, 0);

        // Randomized traffic.
        rand_en = 1;
        for (int n = 0; n < 300; n++) begin
            int          op;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] word;
            logic [31:0] exp;
            logic [2:0]  sz;
            bit          wr;
            bit          legal;
            op = $urandom_range(0, 9);
            wd = $urandom;
            sz = 3'($urandom_range(0, 2));
            wr = 1'($urandom_range(0, 1));
            a  = UART;
            if (op <= 3) begin
                a  = UART | 32'($urandom_range(0, 3));
                wr = 1;
            end else if (op == 4) a = TOHOST | 32'($urandom_range(0, 3));
            else if (op == 5) a = USTAT;
            else if (op == 6) begin a = UART; wr = 0; end
            else if (op == 7) a = $urandom;
            else if (op == 8) begin
                a  = (n % 3 == 0) ? TOHOST : (n % 3 == 1) ? UART : USTAT;
                sz = 3'($urandom_range(3, 7));
            end else a = (n % 2 == 1) ? 32'h80001008 : 32'h8000108c;
            word  = a & ~32'h3;
            legal = (word == TOHOST || word == UART || word == USTAT)
                    && sz <= 3'd2;
            xfer(a, wr, sz, wd, rd, w, err, s1, snap);
            if (!legal) begin
                check("r_err_resp", err, 1);
                check("r_err_wait", w, 1);
                check("r_err_first", s1, 1);
            end else begin
                check("r_ok_resp", err, 0);
                if (wr && word == UART) model_q.push_back(wd[7:0]);
                else check("r_ok_wait", w, 0);
                if (wr && word == TOHOST) begin
                    tohost_m = wd;
                    post_tohost(wd);
                end
                if (!wr) begin
                    exp = (word == TOHOST) ? tohost_m
                        : (word == USTAT) ? status_of(snap) : 32'h0;
                    check("r_rdata", rd, exp);
                end
            end
            check("r_tohost", tohost, tohost_m);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
